source_text_streamer: RTL and testbench

- Transmit side of the source-text character stream used by the program-counter line mapper.
- Walks a byte-wide text buffer held in block RAM and emits one ASCII character at a time, using ready/strobe flow control toward the consumer.
- Pulses `new_line_out` once ahead of the first character of every source line.
- Stops at a NUL byte, at the end of the buffer, or when the line limit is reached.

---
 rtl/source_text_streamer.sv | 109 ++++++++++
 tb/tb_source_text_streamer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/source_text_streamer.sv
// source_text_streamer: walks a byte text buffer in block RAM and streams ASCII characters,
// announcing each source line with a new_line pulse ahead of its first character.
module source_text_streamer #(
  parameter int BUFFER_DEPTH = 4096,
  parameter int NUMBER_LINES = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               start_in,
  output logic [$clog2(BUFFER_DEPTH)-1:0]    mem_addr_out,
  input  logic [7:0]                         mem_data_in,
  input  logic                               ready_in,
  output logic                               new_line_out,
  output logic                               new_character_out,
  output logic [7:0]                         ascii_out,
  output logic [$clog2(NUMBER_LINES+1)-1:0]  line_count_out,
  output logic                               busy_out,
  output logic                               done_out,
  output logic                               overflow_out
);
  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int LW = $clog2(NUMBER_LINES+1);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DECIDE = 3'd3;
  localparam logic [2:0] S_LINE   = 3'd4;
  localparam logic [2:0] S_EMIT   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] WAIT_LOAD = 3'(READ_LATENCY-1);
  logic [2:0]    r_state;
  logic [2:0]    r_wait;
  logic [7:0]    r_byte;
  logic [7:0]    r_ascii;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_line_count;
  logic          r_pending;
  logic          r_overflow;
  logic          w_last;
  logic          w_at_limit;
  logic [2:0]    w_adv_state;
  assign w_last      = r_addr == AW'(BUFFER_DEPTH-1);
  assign w_at_limit  = r_line_count == LW'(NUMBER_LINES);
  assign w_adv_state = w_last ? S_DONE : S_READ;
  assign mem_addr_out      = r_addr;
  assign ascii_out         = r_ascii;
  assign line_count_out    = r_line_count;
  assign overflow_out      = r_overflow;
  assign new_line_out      = (r_state == S_LINE) && ready_in;
  assign new_character_out = (r_state == S_EMIT) && ready_in;
  assign busy_out          = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done_out          = r_state == S_DONE;
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state      <= S_IDLE;
      r_wait       <= '0;
      r_byte       <= '0;
      r_ascii      <= '0;
      r_addr       <= '0;
      r_line_count <= '0;
      r_pending    <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start_in) begin
          r_addr       <= '0;
          r_line_count <= '0;
          r_pending    <= 1'b1;
          r_overflow   <= 1'b0;
          r_state      <= S_READ;
        end
        S_READ: begin
          r_wait  <= WAIT_LOAD;
          r_state <= S_WAIT;
        end
        S_WAIT: if (r_wait == 3'd0) begin
          r_byte  <= mem_data_in;
          r_state <= S_DECIDE;
        end else r_wait <= r_wait - 3'd1;
        S_DECIDE: if (r_byte == 8'h00) r_state <= S_DONE;
        else if (r_byte == 8'h0D) begin
          r_addr  <= w_last ? r_addr : r_addr + AW'(1);
          r_state <= w_adv_state;
        end else if (r_pending && w_at_limit) begin
          r_overflow <= 1'b1;
          r_state    <= S_DONE;
        end else if (r_pending) r_state <= S_LINE;
        else begin
          r_ascii <= r_byte;
          r_state <= S_EMIT;
        end
        S_LINE: if (ready_in) begin
          r_line_count <= r_line_count + LW'(1);
          r_pending    <= 1'b0;
          r_ascii      <= r_byte;
          r_state      <= S_EMIT;
        end
        S_EMIT: if (ready_in) begin
          // an LF arms the announcement of the following line
          r_pending <= r_byte == 8'h0A;
          r_addr    <= w_last ? r_addr : r_addr + AW'(1);
          r_state   <= w_adv_state;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_source_text_streamer.sv
// tb_source_text_streamer: directed checks of the text streamer against hand-computed strobe
// sequences, using a 2-cycle-latency memory model and a 16-byte buffer with a 3-line limit.
module tb_source_text_streamer;
  localparam int NL = 256;
  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       start_in = 1'b0;
  logic       ready_in = 1'b0;
  logic [3:0] mem_addr_out;
  logic [7:0] mem_data_in;
  logic       new_line_out;
  logic       new_character_out;
  logic [7:0] ascii_out;
  logic [1:0] line_count_out;
  logic       busy_out;
  logic       done_out;
  logic       overflow_out;
  logic [7:0] mem [16];
  logic [7:0] pipe0 = '0;
  logic [7:0] pipe1 = '0;
  int n_cmp = 0;
  int n_bad = 0;
  int ev[$];
  int exp_ev[$];
  int viol;
  int chg;
  int lat;
  source_text_streamer #(.BUFFER_DEPTH(16), .NUMBER_LINES(3), .READ_LATENCY(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .mem_addr_out(mem_addr_out),
    .mem_data_in(mem_data_in), .ready_in(ready_in), .new_line_out(new_line_out),
    .new_character_out(new_character_out), .ascii_out(ascii_out),
    .line_count_out(line_count_out), .busy_out(busy_out), .done_out(done_out),
    .overflow_out(overflow_out)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) begin
    pipe0 <= mem[mem_addr_out];
    pipe1 <= pipe0;
  end
  assign mem_data_in = pipe1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic load(input string s, input logic [7:0] fill);
    for (int i = 0; i < 16; i++) mem[i] = fill;
    for (int i = 0; i < s.len() && i < 16; i++) mem[i] = s[i];
  endtask
  task automatic sample();
    if (new_line_out) ev.push_back(NL);
    if (new_character_out) ev.push_back(int'(ascii_out));
    if ((new_line_out || new_character_out) && !ready_in) viol++;
    if (new_line_out && new_character_out) viol++;
  endtask
  task automatic run_stream(input int mode, input int mid_start);
    logic [7:0] prev;
    int c;
    ev.delete();
    viol = 0;
    chg = 0;
    c = 0;
    @(negedge clk_in);
    start_in = 1'b1;
    ready_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    start_in = 1'b0;
    lat = 0;
    prev = ascii_out;
    while (!done_out && lat < 400) begin
      sample();
      if (ascii_out !== prev) chg++;
      prev = ascii_out;
      ready_in = (mode == 0) || (c % 4 == 3);
      start_in = (c == mid_start);
      c++;
      @(posedge clk_in);
      lat++;
      @(negedge clk_in);
    end
    start_in = 1'b0;
    ready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      sample();
    end
  endtask
  task automatic check_events(input string tag);
    check({tag, "_count"}, ev.size(), exp_ev.size());
    for (int i = 0; i < ev.size() && i < exp_ev.size(); i++)
      check($sformatf("%s_ev%0d", tag, i), ev[i], exp_ev[i]);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    @(posedge clk_in);
    @(negedge clk_in);
    check("rst_addr", mem_addr_out, 0);
    check("rst_ascii", ascii_out, 0);
    check("rst_lines", line_count_out, 0);
    check("rst_flags", {busy_out, done_out, overflow_out, new_line_out, new_character_out}, 0);
    rst_in = 1'b0;
    load("ab\ncd", 8'h00);
    run_stream(0, -1);
    exp_ev = '{NL, 8'h61, 8'h62, 8'h0A, NL, 8'h63, 8'h64};
    check_events("basic");
    check("basic_lat", lat, 31);
    check("basic_lines", line_count_out, 2);
    check("basic_done", {busy_out, done_out, overflow_out}, 3'b010);
    check("basic_addr", mem_addr_out, 5);
    check("basic_viol", viol, 0);
    check("basic_chg", chg, 5);
    run_stream(1, 10);
    check_events("stall");
    check("stall_viol", viol, 0);
    check("stall_chg", chg, 5);
    check("stall_lines", line_count_out, 2);
    check("stall_done", done_out, 1);
    load("x\015\n\ny", 8'h00);
    run_stream(0, -1);
    exp_ev = '{NL, 8'h78, 8'h0A, NL, 8'h0A, NL, 8'h79};
    check_events("cr");
    check("cr_lat", lat, 31);
    check("cr_lines", line_count_out, 3);
    check("cr_ovf", overflow_out, 0);
    load("", 8'h00);
    run_stream(0, -1);
    exp_ev = {};
    check_events("nul");
    check("nul_lat", lat, 4);
    check("nul_lines", line_count_out, 0);
    check("nul_done", done_out, 1);
    load("a\nb\nc\nd", 8'h00);
    run_stream(0, -1);
    exp_ev = '{NL, 8'h61, 8'h0A, NL, 8'h62, 8'h0A, NL, 8'h63, 8'h0A};
    check_events("ovf");
    check("ovf_lat", lat, 37);
    check("ovf_flag", overflow_out, 1);
    check("ovf_lines", line_count_out, 3);
    check("ovf_addr", mem_addr_out, 6);
    load("", 8'h7A);
    run_stream(0, -1);
    exp_ev = '{NL};
    for (int i = 0; i < 16; i++) exp_ev.push_back(8'h7A);
    check_events("full");
    check("full_lat", lat, 81);
    check("full_addr", mem_addr_out, 15);
    check("full_done", done_out, 1);
    check("full_ovf_cleared", overflow_out, 0);
    check("full_lines", line_count_out, 1);
    load("ab\ncd", 8'h00);
    @(negedge clk_in);
    start_in = 1'b1;
    ready_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (12) @(negedge clk_in);
    check("mid_busy", busy_out, 1);
    check("mid_lines", line_count_out, 1);
    rst_in = 1'b1;
    #1;
    check("arst_addr", mem_addr_out, 0);
    check("arst_ascii", ascii_out, 0);
    check("arst_lines", line_count_out, 0);
    check("arst_flags", {busy_out, done_out, overflow_out, new_line_out, new_character_out}, 0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    ev.delete();
    viol = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_in);
      sample();
    end
    check("arst_quiet", ev.size(), 0);
    check("arst_idle", busy_out, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
